// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Purpose  : Shared constants, ALU operation encoding and immediate helpers
//            for the single-cycle RV32I-subset core.
// Revision : 1.0 - initial release
// ============================================================================
package risc_pkg;

  localparam int c_xlen      = 32;
  localparam int c_nregs     = 32;
  localparam int c_rom_depth = 64;
  localparam int c_ram_depth = 64;

  // Major opcodes
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  // funct3 values
  localparam logic [2:0] c_f3_add = 3'b000;
  localparam logic [2:0] c_f3_slt = 3'b010;
  localparam logic [2:0] c_f3_xor = 3'b100;
  localparam logic [2:0] c_f3_or  = 3'b110;
  localparam logic [2:0] c_f3_and = 3'b111;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_sw  = 3'b010;
  localparam logic [2:0] c_f3_beq = 3'b000;

  // funct7 values
  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_sub  = 7'b0100000;

  // Canonical NOP (addi x0,x0,0)
  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_PASS = 3'd6
  } alu_op_e;

  // Sign-extend a 12-bit immediate to XLEN
  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage : risc_pkg
`default_nettype wire

// File: rtl/risc_processor_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Combinational 32-bit ALU (add, sub, logic ops, signed compare,
//            pass-through of operand B).
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import risc_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_y
);

  // Select the result of the requested operation; arithmetic wraps mod 2^32
  always_comb begin
    o_y = 32'h0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SLT:  o_y = {31'h0, ($signed(i_a) < $signed(i_b))};
      ALU_PASS: o_y = i_b;
      default:  o_y = 32'h0;
    endcase
  end

endmodule : alu
`default_nettype wire

// File: rtl/risc_processor_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : 64 x 32-bit word-addressed data RAM, combinational read and
//            synchronous write. Not cleared by reset.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [5:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] mem [0:c_ram_depth-1];

  // Store the word at the clock edge
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
  end

  // Load path is combinational within the cycle
  always_comb begin
    o_rdata = mem[i_addr];
  end

endmodule : data_memory
`default_nettype wire

// File: rtl/risc_processor_regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : 32 x 32-bit register file, two combinational read ports and one
//            synchronous write port. x0 is hard-wired to zero. Contents are
//            deliberately not reset so preloaded values survive reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] registers [0:c_nregs-1];

  // Commit writeback at the clock edge; writes aimed at x0 are dropped
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != 5'd0)) begin
      registers[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous reads return the pre-edge value, x0 always reads zero
  always_comb begin
    o_rdata1 = (i_raddr1 == 5'd0) ? 32'h0 : registers[i_raddr1];
    o_rdata2 = (i_raddr2 == 5'd0) ? 32'h0 : registers[i_raddr2];
  end

endmodule : regfile
`default_nettype wire

// File: rtl/risc_processor.sv
`default_nettype none
// ============================================================================
// Module   : risc_processor
// Purpose  : Single-cycle RV32I-subset core with built-in program ROM,
//            register file (reg_file) and data RAM (data_mem). Fetch, decode,
//            execute, memory and writeback all complete in one clock.
// Revision : 1.0 - initial release
// ============================================================================
module risc_processor
  import risc_pkg::*;
(
  input logic clk,
  input logic rst
);

  // Only 256 bytes of code space exist, so the PC wraps naturally at 8 bits
  logic [7:0]  r_pc;
  logic [31:0] w_instr;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [7:0]  w_imm_b;

  logic        w_rf_we;
  logic        w_mem_we;
  logic        w_use_imm;
  logic        w_wb_mem;
  logic        w_branch;
  logic [31:0] w_imm;
  alu_op_e     w_alu_op;

  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_y;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_wb_data;
  logic        w_taken;
  logic [7:0]  w_pc_next;
  logic        w_unused;

  // Program ROM, indexed by word address
  always_comb begin
    w_instr = c_nop;
    case (r_pc[7:2])
      6'd0:    w_instr = 32'h0020_81B3;  // add  x3,x1,x2
      6'd1:    w_instr = 32'h4020_8233;  // sub  x4,x1,x2
      6'd2:    w_instr = 32'h0020_C2B3;  // xor  x5,x1,x2
      6'd3:    w_instr = 32'h0000_2303;  // lw   x6,0(x0)
      6'd4:    w_instr = 32'h0000_8393;  // addi x7,x1,0
      default: w_instr = c_nop;
    endcase
  end

  // Instruction field and immediate extraction
  always_comb begin
    w_opcode = w_instr[6:0];
    w_rd     = w_instr[11:7];
    w_f3     = w_instr[14:12];
    w_rs1    = w_instr[19:15];
    w_rs2    = w_instr[24:20];
    w_f7     = w_instr[31:25];
    w_imm_i  = sext12(w_instr[31:20]);
    w_imm_s  = sext12({w_instr[31:25], w_instr[11:7]});
    // Only offset bits [7:0] can affect an 8-bit PC
    w_imm_b  = {w_instr[27:25], w_instr[11:8], 1'b0};
  end

  // Decode: unsupported encodings fall through as NOPs (no writes, PC+4)
  always_comb begin
    w_rf_we   = 1'b0;
    w_mem_we  = 1'b0;
    w_use_imm = 1'b0;
    w_wb_mem  = 1'b0;
    w_branch  = 1'b0;
    w_imm     = w_imm_i;
    w_alu_op  = ALU_ADD;
    case (w_opcode)
      c_op_rtype: begin
        if (w_f7 == c_f7_base) begin
          w_rf_we = 1'b1;
          case (w_f3)
            c_f3_add: w_alu_op = ALU_ADD;
            c_f3_slt: w_alu_op = ALU_SLT;
            c_f3_xor: w_alu_op = ALU_XOR;
            c_f3_or:  w_alu_op = ALU_OR;
            c_f3_and: w_alu_op = ALU_AND;
            default:  w_rf_we  = 1'b0;
          endcase
        end else if ((w_f7 == c_f7_sub) && (w_f3 == c_f3_add)) begin
          w_rf_we  = 1'b1;
          w_alu_op = ALU_SUB;
        end
      end
      c_op_itype: begin
        w_use_imm = 1'b1;
        w_rf_we   = 1'b1;
        case (w_f3)
          c_f3_add: w_alu_op = ALU_ADD;
          c_f3_xor: w_alu_op = ALU_XOR;
          c_f3_or:  w_alu_op = ALU_OR;
          c_f3_and: w_alu_op = ALU_AND;
          default:  w_rf_we  = 1'b0;
        endcase
      end
      c_op_load: begin
        if (w_f3 == c_f3_lw) begin
          w_use_imm = 1'b1;
          w_rf_we   = 1'b1;
          w_wb_mem  = 1'b1;
        end
      end
      c_op_store: begin
        if (w_f3 == c_f3_sw) begin
          w_use_imm = 1'b1;
          w_imm     = w_imm_s;
          w_mem_we  = 1'b1;
        end
      end
      c_op_branch: begin
        if (w_f3 == c_f3_beq) begin
          w_branch = 1'b1;
          w_alu_op = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  // Writes are suppressed while reset is asserted
  regfile reg_file (
    .clk      (clk),
    .i_we     (w_rf_we && !rst),
    .i_waddr  (w_rd),
    .i_wdata  (w_wb_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  alu u_alu (
    .i_a  (w_rs1_data),
    .i_b  (w_alu_b),
    .i_op (w_alu_op),
    .o_y  (w_alu_y)
  );

  data_memory data_mem (
    .clk     (clk),
    .i_we    (w_mem_we && !rst),
    .i_addr  (w_alu_y[7:2]),
    .i_wdata (w_rs2_data),
    .o_rdata (w_mem_rdata)
  );

  // Operand selection, writeback mux and next-PC computation
  always_comb begin
    w_alu_b   = w_use_imm ? w_imm : w_rs2_data;
    w_wb_data = w_wb_mem ? w_mem_rdata : w_alu_y;
    w_taken   = w_branch && (w_alu_y == 32'h0);
    w_pc_next = w_taken ? (r_pc + w_imm_b) : (r_pc + 8'd4);
    // Upper and byte-offset address bits are intentionally ignored
    w_unused  = ^{w_alu_y[31:8], w_alu_y[1:0]};
  end

  // PC register: reset returns to the first instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= 8'h00;
    end else begin
      r_pc <= w_pc_next;
    end
  end

endmodule : risc_processor
`default_nettype wire

// File: tb/tb_risc_processor.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_processor
// Purpose  : Self-checking bench for risc_processor. Expected architectural
//            state is queued as each scenario is driven and compared against
//            the register file, data RAM and PC once the cycles have run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_processor;

  localparam logic [31:0] c_sent = 32'hDEAD_BEEF;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;
  int n_cyc;   // edges since reset was released

  typedef struct {
    string       tag;
    int          kind;  // 0 register, 1 data RAM word, 2 PC
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];

  risc_processor dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      0:       return dut.reg_file.registers[idx];
      1:       return dut.data_mem.mem[idx];
      default: return {24'h0, dut.r_pc};
    endcase
  endfunction

  function automatic void expect_val(input string tag, input int kind, input int idx,
                                     input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb_q.push_back(e);
  endfunction

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  // Advance n rising edges, finishing on the following falling edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) n_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst   = 1'b0;
    n_cyc = 0;
  endtask

  task automatic preload(input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] m0);
    dut.reg_file.registers[0] = 32'h0;
    dut.reg_file.registers[1] = x1;
    dut.reg_file.registers[2] = x2;
    dut.data_mem.mem[0]       = m0;
    for (int r = 3; r <= 8; r++) dut.reg_file.registers[r] = c_sent;
    dut.data_mem.mem[1] = c_sent;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_cyc = 0;
    rst   = 1'b1;
    @(negedge clk);

    // Reset retention over a 3-edge reset
    preload(32'd5, 32'd3, 32'h0000_000A);
    do_reset(3);
    expect_val("rst_pc",     2, 0, 32'h0);
    expect_val("rst_x1",     0, 1, 32'd5);
    expect_val("rst_x2",     0, 2, 32'd3);
    expect_val("rst_mem0",   1, 0, 32'h0000_000A);
    expect_val("rst_x3_nowr", 0, 3, c_sent);
    drain();

    // First instruction commits on the first edge only
    tick(1);
    expect_val("lat_x3", 0, 3, 32'h0000_0008);
    expect_val("lat_x4", 0, 4, c_sent);
    expect_val("lat_pc", 2, 0, 32'h4);
    drain();

    // Remainder of the built-in program
    tick(5);
    expect_val("p1_x3", 0, 3, 32'h0000_0008);
    expect_val("p1_x4", 0, 4, 32'h0000_0002);
    expect_val("p1_x5", 0, 5, 32'h0000_0006);
    expect_val("p1_x6", 0, 6, 32'h0000_000A);
    expect_val("p1_x7", 0, 7, 32'h0000_0005);
    drain();

    // Free-run through the NOP region and PC wrap
    tick(100);
    expect_val("fr_x3", 0, 3, 32'h0000_0008);
    expect_val("fr_x4", 0, 4, 32'h0000_0002);
    expect_val("fr_x5", 0, 5, 32'h0000_0006);
    expect_val("fr_x6", 0, 6, 32'h0000_000A);
    expect_val("fr_x7", 0, 7, 32'h0000_0005);
    expect_val("fr_pc", 2, 0, (n_cyc * 4) % 256);
    drain();
    check("fr_pc_known", {31'h0, $isunknown(dut.r_pc)}, 32'h0);

    // SUB wrap-around
    preload(32'd3, 32'd5, 32'h0000_000A);
    do_reset(1);
    tick(6);
    expect_val("p2_x3", 0, 3, 32'h0000_0008);
    expect_val("p2_x4", 0, 4, 32'hFFFF_FFFE);
    expect_val("p2_x5", 0, 5, 32'h0000_0006);
    drain();

    // Reset in the middle of the program
    preload(32'd5, 32'd3, 32'h0000_000A);
    do_reset(1);
    tick(2);
    expect_val("mid_x3a", 0, 3, 32'h0000_0008);
    expect_val("mid_x4a", 0, 4, 32'h0000_0002);
    expect_val("mid_x5a", 0, 5, c_sent);
    drain();
    dut.reg_file.registers[1] = 32'd7;
    do_reset(1);
    expect_val("mid_pc0", 2, 0, 32'h0);
    expect_val("mid_x5_nowr", 0, 5, c_sent);
    drain();
    tick(5);
    expect_val("mid_x3", 0, 3, 32'h0000_000A);
    expect_val("mid_x4", 0, 4, 32'h0000_0004);
    expect_val("mid_x5", 0, 5, 32'h0000_0004);
    expect_val("mid_x7", 0, 7, 32'h0000_0007);
    drain();

    // Alternate word 0: add x0,x1,x2 must leave x0 at zero
    preload(32'd5, 32'd3, 32'h0000_000A);
    do_reset(1);
    force dut.w_instr = 32'h0020_8033;
    tick(1);
    release dut.w_instr;
    expect_val("x0_kept", 0, 0, 32'h0);
    expect_val("x0_x3",   0, 3, c_sent);
    drain();

    // Alternate instructions: sw x1,4(x0); beq x0,x0,+16; slt x8,x1,x2
    preload(32'hFFFF_FFFF, 32'd3, 32'h0000_000A);
    do_reset(1);
    force dut.w_instr = 32'h0010_2223;
    tick(1);
    release dut.w_instr;
    expect_val("sw_mem1", 1, 1, 32'hFFFF_FFFF);
    expect_val("sw_pc",   2, 0, 32'h4);
    expect_val("sw_mem0", 1, 0, 32'h0000_000A);
    drain();
    force dut.w_instr = 32'h0000_0863;
    tick(1);
    release dut.w_instr;
    expect_val("beq_pc", 2, 0, 32'd20);
    drain();
    force dut.w_instr = 32'h0020_A433;
    tick(1);
    release dut.w_instr;
    expect_val("slt_x8", 0, 8, 32'h1);
    expect_val("slt_pc", 2, 0, 32'd24);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, got running expected finished");
    $fatal(1);
  end

endmodule : tb_risc_processor
`default_nettype wire
